// File: rtl/orde_rob_ctrl.sv
// orde_rob_ctrl: reorder-buffer controller sitting on the host side of the
// read-reordering CAM. It allocates slots in issue order and inserts each key.
// It searches returning responses and stores their data in the oldest matching
// slot. It retires slots in allocation order into a one-entry output register.
module orde_rob_ctrl #(
  parameter int CAM_DEPTH  = 32,
  parameter int CAM_WIDTH  = 23,
  parameter int DATA_WIDTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [CAM_WIDTH-1:0]          req_key,
  output logic                          req_ready,
  output logic [$clog2(CAM_DEPTH)-1:0]  req_idx,
  output logic [CAM_WIDTH-1:0]          cam_in,
  output logic                          cam_in_valid,
  output logic [$clog2(CAM_DEPTH)-1:0]  cam_in_idx,
  input  logic                          rsp_valid,
  input  logic [CAM_WIDTH-1:0]          rsp_key,
  input  logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_ready,
  output logic                          cam_key_valid,
  output logic [CAM_WIDTH-1:0]          cam_key,
  input  logic [CAM_DEPTH-1:0]          match_entry_array,
  output logic [$clog2(CAM_DEPTH)-1:0]  match_idx,
  output logic                          match_idx_valid,
  output logic                          status_mem_idx_valid,
  output logic [$clog2(CAM_DEPTH)-1:0]  status_mem_idx,
  input  logic                          status,
  output logic                          pop_idx_valid,
  output logic [$clog2(CAM_DEPTH)-1:0]  pop_idx,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(CAM_DEPTH)-1:0]  out_idx,
  input  logic                          out_ready,
  output logic                          rsp_err,
  output logic [$clog2(CAM_DEPTH):0]    occupancy
);

  localparam int IW = $clog2(CAM_DEPTH);
  localparam logic [IW:0]   FULL_CNT = (IW+1)'(CAM_DEPTH);
  localparam logic [IW:0]   ONE_CNT  = (IW+1)'(1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  logic [IW-1:0]         head_q, head_d;
  logic [IW-1:0]         tail_q, tail_d;
  logic [IW:0]           count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]         out_idx_q, out_idx_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0] data_ram [CAM_DEPTH];

  logic                  accept;
  logic                  pop;
  logic                  any_match;
  logic [CAM_DEPTH-1:0]  match_rot;
  logic [IW-1:0]         match_enc;

  // Allocation side: insert new keys at the tail while a slot is free
  always_comb begin
    req_ready    = (count_q != FULL_CNT);
    accept       = req_valid & req_ready;
    req_idx      = tail_q;
    cam_in       = req_key;
    cam_in_valid = accept;
    cam_in_idx   = tail_q;
  end

  // Search side: rotate the match vector so bit 0 is the head, then the
  // lowest set bit is the oldest outstanding slot carrying this key
  always_comb begin
    rsp_ready     = 1'b1;
    cam_key_valid = rsp_valid;
    cam_key       = rsp_key;
    match_rot     = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      match_rot[i] = match_entry_array[IW'(i) + head_q];
    end
    match_enc = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (match_rot[i]) match_enc = IW'(i);
    end
    any_match       = |match_entry_array;
    match_idx       = match_enc + head_q;
    match_idx_valid = rsp_valid & any_match;
  end

  // Retire side: poll the head slot and pop it once its data has landed
  // and the output register is free or being drained this cycle
  always_comb begin
    status_mem_idx       = head_q;
    status_mem_idx_valid = (count_q != '0);
    pop                  = status_mem_idx_valid & status & (~out_valid_q | out_ready);
    pop_idx_valid        = pop;
    pop_idx              = head_q;
    out_valid            = out_valid_q;
    out_data             = out_data_q;
    out_idx              = out_idx_q;
    rsp_err              = rsp_err_q;
    occupancy            = count_q;
  end

  // Next-state for pointers, count and the output register
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    rsp_err_d   = rsp_valid & ~any_match;
    if (accept) tail_d = tail_q + ONE_IDX;
    if (pop) begin
      head_d      = head_q + ONE_IDX;
      out_valid_d = 1'b1;
      out_data_d  = data_ram[head_q];
      out_idx_d   = head_q;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Response data store; contents are only read after a slot is filled
  always_ff @(posedge clk) begin
    if (match_idx_valid) data_ram[match_idx] <= rsp_data;
  end

endmodule

// File: doc/orde_rob_ctrl.md
Name: orde_rob_ctrl

Overview:
- Reorder-buffer controller that drives the read-reordering CAM from its host side.
- Allocates CAM slots in issue order and inserts each read key into the CAM.
- Presents returning response keys to the CAM for search, picks the oldest matching slot, and stores the response data there.
- Retires slots strictly in allocation order by polling the CAM status bit and popping the head, so the downstream PIM datapath sees in-order read data.

Parameters:
CAM_DEPTH, 32, number of reorder slots (power of two)
CAM_WIDTH, 23, read key (address/tag) width
DATA_WIDTH, 256, response data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  new read request
req_key  in  CAM_WIDTH  key of new request
req_ready  out  1  slot available
req_idx  out  $clog2(CAM_DEPTH)  slot assigned to accepted request (= tail)
cam_in  out  CAM_WIDTH  key written into CAM
cam_in_valid  out  1  CAM insert strobe
cam_in_idx  out  $clog2(CAM_DEPTH)  CAM insert slot
rsp_valid  in  1  read response present
rsp_key  in  CAM_WIDTH  response key
rsp_data  in  DATA_WIDTH  response data
rsp_ready  out  1  always 1 after reset
cam_key_valid  out  1  CAM search strobe
cam_key  out  CAM_WIDTH  CAM search key
match_entry_array  in  CAM_DEPTH  combinational CAM match vector
match_idx  out  $clog2(CAM_DEPTH)  selected slot
match_idx_valid  out  1  commit match
status_mem_idx_valid  out  1  status query strobe
status_mem_idx  out  $clog2(CAM_DEPTH)  status query slot (= head)
status  in  1  queried slot has data
pop_idx_valid  out  1  retire strobe
pop_idx  out  $clog2(CAM_DEPTH)  retired slot
out_valid  out  1  in-order data available
out_data  out  DATA_WIDTH  retired data
out_idx  out  $clog2(CAM_DEPTH)  slot of out_data
out_ready  in  1  consumer accepts
rsp_err  out  1  one-cycle pulse: response matched no slot
occupancy  out  $clog2(CAM_DEPTH)+1  slots in use

Behaviour:
- Reset (async): head=0, tail=0, count=0, out_valid=0, out_data=0, out_idx=0, rsp_err=0. Data RAM is not reset.
- Combinational outputs after reset: req_ready=1, rsp_ready=1, all strobes 0.
- Allocate:
  - req_ready = (count != CAM_DEPTH).
  - cam_in_valid = req_valid & req_ready; cam_in = req_key; cam_in_idx = req_idx = tail.
  - On accept, tail <= tail+1 (wraps modulo CAM_DEPTH).
- Search (combinational, same cycle): cam_key_valid = rsp_valid; cam_key = rsp_key.
  - Rotate match_entry_array right by head and priority-encode from bit 0, so the oldest match wins; match_idx = (enc + head) mod CAM_DEPTH.
  - match_idx_valid = rsp_valid & |match_entry_array.
  - When match_idx_valid, data_ram[match_idx] <= rsp_data at the clock edge.
  - When rsp_valid and there is no match, the response is dropped and rsp_err <= 1 for the next cycle only.
- Retire:
  - status_mem_idx = head; status_mem_idx_valid = (count != 0).
  - pop = (count != 0) & status & (!out_valid | out_ready).
  - When pop: pop_idx_valid = 1, pop_idx = head; at the edge out_data <= data_ram[head], out_idx <= head, out_valid <= 1, head <= head+1 (wraps).
  - When out_valid & out_ready & !pop: out_valid <= 0.
- Latency: response committed in cycle N -> CAM status set at edge N -> pop in cycle N+1 -> out_valid in cycle N+2 (if head and output stage free).
- Count:
  - count <= count + accept - pop; simultaneous accept and pop leaves count unchanged.
  - occupancy = count; it includes the slot held in the output register only until it is popped.
- Boundaries:
  - Full (count = CAM_DEPTH): req_ready = 0 and no cam_in_valid; a pop in the same cycle does not reopen ready until the next cycle.
  - Empty: no status query and no pop.
  - An insert and a pop never target the same slot: tail equals head only when count is 0 or CAM_DEPTH.
  - A response for the head slot in cycle N pops in N+1 and never in N.
  - Out-of-order responses are held in slots until all older slots retire.
  - out_valid/out_data hold stable while !out_ready.
  - Reset mid-operation discards all slots; the CAM itself is not reset, but stale CAM entries are cleared on their next insert.

Test Plan:
- Reset, then 4 requests with keys 0x10..0x13 -> cam_in_idx 0,1,2,3; req_idx matches; occupancy 4; rsp responses in order -> out_data in order, out_idx 0..3, each out_valid 2 cycles after its response.
- Requests 0xA,0xB,0xC; responses in order C,B,A -> no out_valid until A returns, then out_idx 0,1,2 on three consecutive cycles (out_ready=1).
- Two requests with the same key 0x55 in slots 0 and 1; one response -> match_idx 0, slot 1 is still pending; second response -> match_idx 1.
- Fill 32 slots -> req_ready=0 at occupancy 32; retire one -> req_ready=1 the following cycle; next insert uses cam_in_idx 0 (wrap).
- Response key 0x7FF matching no slot -> match_idx_valid=0, rsp_err high for exactly 1 cycle, occupancy unchanged.
- Hold out_ready=0 with 2 completed slots -> out_data/out_idx stable, only one pop; release -> second pop the next cycle; assert rst mid-stream -> out_valid=0 and occupancy=0 immediately.
